// File: rtl/ppu_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ppu_timing_ctrl
// Purpose  : Scan-line and frame sequencer for the PPU. Owns the dot counter,
//            the current line (LY) and the current PPU mode. Issues start
//            strobes to the OAM-scan and pixel-fetch datapaths, accepts the
//            pixel pipeline's completion, and raises the VBlank and the
//            edge-detected STAT interrupt requests.
// Ports    : clk, rst_n          clock, asynchronous active-low reset
//            dot_en              advance one dot this cycle
//            lcd_en              LCDC[7], LCD enable
//            lyc[7:0]            LY compare value
//            stat_ie[3:0]        STAT sources: 0 HBLANK, 1 VBLANK, 2 OAM, 3 LYC
//            draw_done           pixel pipeline finished the line
//            mode[1:0]           current PPU mode (0..3)
//            ly[7:0], dot[8:0]   current line / dot within the line
//            lyc_match           registered LY==LYC
//            oam_start           strobe, mode 2 begins
//            draw_start          strobe, mode 3 begins
//            draw_timeout        strobe, mode 3 forced to end
//            vblank_irq          VBlank interrupt request (one clk)
//            stat_irq            STAT interrupt request (one clk)
// Revision : 1.0 - initial release
// ============================================================================
module ppu_timing_ctrl #(
   parameter int DOTS_PER_LINE   = 456,
   parameter int LINES_PER_FRAME = 154,
   parameter int VISIBLE_LINES   = 144,
   parameter int OAM_DOTS        = 80,
   parameter int MODE3_MAX_DOTS  = 289
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       dot_en,
   input  logic       lcd_en,
   input  logic [7:0] lyc,
   input  logic [3:0] stat_ie,
   input  logic       draw_done,
   output logic [1:0] mode,
   output logic [7:0] ly,
   output logic [8:0] dot,
   output logic       lyc_match,
   output logic       oam_start,
   output logic       draw_start,
   output logic       draw_timeout,
   output logic       vblank_irq,
   output logic       stat_irq
);

   // ppu_mode_t encoding
   localparam logic [1:0] PPU_MODE_0 = 2'd0;   // HBLANK
   localparam logic [1:0] PPU_MODE_1 = 2'd1;   // VBLANK
   localparam logic [1:0] PPU_MODE_2 = 2'd2;   // OAM scan
   localparam logic [1:0] PPU_MODE_3 = 2'd3;   // pixel transfer

   // sequencer states
   localparam logic [2:0] ST_OFF    = 3'd0;
   localparam logic [2:0] ST_OAM    = 3'd1;
   localparam logic [2:0] ST_DRAW   = 3'd2;
   localparam logic [2:0] ST_HBLANK = 3'd3;
   localparam logic [2:0] ST_VBLANK = 3'd4;

   // counter landmarks
   localparam logic [8:0] DOT_LAST    = 9'(DOTS_PER_LINE - 1);
   localparam logic [8:0] DOT_DRAW    = 9'(OAM_DOTS);
   localparam logic [8:0] DOT_TIMEOUT = 9'(OAM_DOTS + MODE3_MAX_DOTS);
   localparam logic [7:0] LY_LAST     = 8'(LINES_PER_FRAME - 1);
   localparam logic [7:0] LY_VBLANK   = 8'(VISIBLE_LINES);

   logic [2:0] state;
   logic [2:0] state_nxt;
   logic [8:0] dot_nxt;
   logic [7:0] ly_nxt;
   logic [1:0] mode_nxt;
   logic       oam_start_nxt;
   logic       draw_start_nxt;
   logic       draw_timeout_nxt;
   logic       vblank_irq_nxt;

   logic       line_wrap;
   logic [8:0] dot_inc;
   logic [7:0] ly_inc;

   logic       stat_line;
   logic       stat_line_q;

   // ------------------------------------------------------------------------
   // Counter arithmetic
   // ------------------------------------------------------------------------
   assign line_wrap = (dot == DOT_LAST);
   assign dot_inc   = line_wrap ? 9'd0 : dot + 9'd1;
   assign ly_inc    = (ly == LY_LAST) ? 8'd0 : ly + 8'd1;

   // ------------------------------------------------------------------------
   // Next-state logic. Everything here only moves on a dot_en cycle, except
   // the LCD-off path which takes effect on the next clk unconditionally.
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt        = state;
      dot_nxt          = dot;
      ly_nxt           = ly;
      oam_start_nxt    = 1'b0;
      draw_start_nxt   = 1'b0;
      draw_timeout_nxt = 1'b0;
      vblank_irq_nxt   = 1'b0;

      if (!lcd_en) begin
         state_nxt = ST_OFF;
         dot_nxt   = 9'd0;
         ly_nxt    = 8'd0;
      end else if (dot_en) begin
         if (state == ST_OFF) begin
            // first enabled dot is dot 0 of line 0, already in OAM scan
            state_nxt     = ST_OAM;
            dot_nxt       = 9'd0;
            ly_nxt        = 8'd0;
            oam_start_nxt = 1'b1;
         end else begin
            dot_nxt = dot_inc;
            if (line_wrap) begin
               // a wrap overrides anything pending on the old line,
               // including a draw_done arriving on the last dot
               ly_nxt = ly_inc;
               if (ly_inc < LY_VBLANK) begin
                  state_nxt     = ST_OAM;
                  oam_start_nxt = 1'b1;
               end else begin
                  state_nxt      = ST_VBLANK;
                  vblank_irq_nxt = (ly_inc == LY_VBLANK);
               end
            end else begin
               case (state)
                  ST_OAM: begin
                     if (dot_inc == DOT_DRAW) begin
                        state_nxt      = ST_DRAW;
                        draw_start_nxt = 1'b1;
                     end
                  end
                  ST_DRAW: begin
                     // draw_done takes priority over the watchdog
                     if (draw_done) begin
                        state_nxt = ST_HBLANK;
                     end else if (dot_inc == DOT_TIMEOUT) begin
                        state_nxt        = ST_HBLANK;
                        draw_timeout_nxt = 1'b1;
                     end
                  end
                  default: begin
                     // HBLANK and VBLANK hold until the line wraps
                  end
               endcase
            end
         end
      end
   end

   // mode output is registered alongside the state to stay glitch-free
   always_comb begin
      mode_nxt = PPU_MODE_0;
      case (state_nxt)
         ST_OAM:    mode_nxt = PPU_MODE_2;
         ST_DRAW:   mode_nxt = PPU_MODE_3;
         ST_VBLANK: mode_nxt = PPU_MODE_1;
         default:   mode_nxt = PPU_MODE_0;
      endcase
   end

   // ------------------------------------------------------------------------
   // STAT interrupt line, built from registered state only
   // ------------------------------------------------------------------------
   always_comb begin
      stat_line = 1'b0;
      if (state != ST_OFF) begin
         stat_line = (stat_ie[0] & (state == ST_HBLANK))
                   | (stat_ie[1] & (state == ST_VBLANK))
                   | (stat_ie[2] & (state == ST_OAM))
                   | (stat_ie[3] & lyc_match);
      end
   end

   // ------------------------------------------------------------------------
   // Sequencer registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_OFF;
         dot          <= 9'd0;
         ly           <= 8'd0;
         mode         <= PPU_MODE_0;
         oam_start    <= 1'b0;
         draw_start   <= 1'b0;
         draw_timeout <= 1'b0;
         vblank_irq   <= 1'b0;
      end else begin
         state        <= state_nxt;
         dot          <= dot_nxt;
         ly           <= ly_nxt;
         mode         <= mode_nxt;
         oam_start    <= oam_start_nxt;
         draw_start   <= draw_start_nxt;
         draw_timeout <= draw_timeout_nxt;
         vblank_irq   <= vblank_irq_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // LY compare and STAT edge detector. These run every clk, independent of
   // dot_en, so an LYC write shows up one clk later even while dots stall.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lyc_match   <= 1'b0;
         stat_line_q <= 1'b0;
         stat_irq    <= 1'b0;
      end else if (!lcd_en || (state == ST_OFF)) begin
         lyc_match   <= 1'b0;
         stat_line_q <= 1'b0;
         stat_irq    <= 1'b0;
      end else begin
         lyc_match   <= (ly == lyc);
         stat_line_q <= stat_line;
         // a line that is already high blocks further requests
         stat_irq    <= stat_line & ~stat_line_q;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ppu_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_timing_ctrl
// Purpose  : Directed self-checking bench for ppu_timing_ctrl at default
//            parameters: one full frame with scripted draw_done events, LYC
//            STAT interrupt and blocking, LCD off/on, sparse dot_en and an
//            asynchronous reset in mid-line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppu_timing_ctrl;

   logic       clk;
   logic       rst_n;
   logic       dot_en;
   logic       lcd_en;
   logic [7:0] lyc;
   logic [3:0] stat_ie;
   logic       draw_done;
   logic [1:0] mode;
   logic [7:0] ly;
   logic [8:0] dot;
   logic       lyc_match;
   logic       oam_start;
   logic       draw_start;
   logic       draw_timeout;
   logic       vblank_irq;
   logic       stat_irq;

   int total;
   int bad;

   ppu_timing_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dot_en       (dot_en),
      .lcd_en       (lcd_en),
      .lyc          (lyc),
      .stat_ie      (stat_ie),
      .draw_done    (draw_done),
      .mode         (mode),
      .ly           (ly),
      .dot          (dot),
      .lyc_match    (lyc_match),
      .oam_start    (oam_start),
      .draw_start   (draw_start),
      .draw_timeout (draw_timeout),
      .vblank_irq   (vblank_irq),
      .stat_irq     (stat_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // one clk; inputs change and outputs are sampled 1 ns after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int n_oam, n_ds, n_to, n_vb, n_stat, n_m1, stat_k, ds_dot, n_en;

   initial begin
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      dot_en    = 1'b0;
      lcd_en    = 1'b0;
      lyc       = 8'd200;
      stat_ie   = 4'b1000;
      draw_done = 1'b0;

      // ---------------- reset state ----------------
      #2;
      check("rst_mode", mode, 0);
      check("rst_dot", dot, 0);
      check("rst_ly", ly, 0);
      check("rst_strobes", {oam_start, draw_start, draw_timeout, vblank_irq, stat_irq, lyc_match}, 0);
      tick();
      tick();
      rst_n  = 1'b1;
      lcd_en = 1'b1;
      dot_en = 1'b1;
      lyc    = 8'd5;
      tick();
      check("on_oam_start", oam_start, 1);
      check("on_mode", mode, 2);
      check("on_dot_ly", {ly, dot}, 0);

      // ---------------- one full frame ----------------
      // after edge k of the frame: dot = k % 456, ly = k / 456
      n_oam = 0; n_ds = 0; n_to = 0; n_vb = 0; n_stat = 0; n_m1 = 0; stat_k = -1;
      for (int k = 1; k <= 70224; k++) begin
         draw_done = (k == 253) || (k == 3*456 + 11) || (k == 3*456 + 81);
         stat_ie   = (k > 5*456 + 300 && k <= 6*456 + 10) ? 4'b1001 : 4'b1000;
         tick();
         if (oam_start)    n_oam++;
         if (draw_start)   n_ds++;
         if (draw_timeout) n_to++;
         if (vblank_irq)   n_vb++;
         if (mode == 2'd1) n_m1++;
         if (stat_irq) begin
            n_stat++;
            stat_k = k;
         end
         case (k)
            80:       check("l0_draw_start", {draw_start, mode, dot}, {1'b1, 2'd3, 9'd80});
            252:      check("l0_still_draw", mode, 3);
            253:      check("l0_hblank", {mode, dot}, {2'd0, 9'd253});
            455:      check("l0_last_dot", {mode, ly, dot}, {2'd0, 8'd0, 9'd455});
            456:      check("l1_wrap", {oam_start, mode, ly, dot}, {1'b1, 2'd2, 8'd1, 9'd0});
            824:      check("l1_pre_timeout", {draw_timeout, mode}, {1'b0, 2'd3});
            825:      check("l1_timeout", {draw_timeout, mode, dot}, {1'b1, 2'd0, 9'd369});
            992:      check("l2_draw_start", {draw_start, mode, ly}, {1'b1, 2'd3, 8'd2});
            1379:     check("l3_oam_ignore_done", mode, 2);
            1449:     check("l3_min_draw", {mode, dot}, {2'd0, 9'd81});
            2280:     check("lyc_pre", {ly, lyc_match}, {8'd5, 1'b0});
            2281:     check("lyc_rise", lyc_match, 1);
            65664:    check("vblank_entry", {vblank_irq, mode, ly, dot}, {1'b1, 2'd1, 8'd144, 9'd0});
            70223:    check("frame_last", {mode, ly, dot}, {2'd1, 8'd153, 9'd455});
            70224:    check("frame_wrap", {oam_start, mode, ly, dot}, {1'b1, 2'd2, 8'd0, 9'd0});
            default: ;
         endcase
      end
      draw_done = 1'b0;
      stat_ie   = 4'b0000;
      check("cnt_oam_start", n_oam, 144);
      check("cnt_draw_start", n_ds, 144);
      check("cnt_timeout", n_to, 142);
      check("cnt_vblank", n_vb, 1);
      check("cnt_mode1", n_m1, 4560);
      check("cnt_stat", n_stat, 1);
      check("stat_edge", stat_k, 2282);

      // ---------------- LCD off in mid-DRAW ----------------
      lyc = 8'd2;
      for (int k = 0; k < 912 + 100; k++) tick();
      check("pre_off", {mode, ly, dot, lyc_match}, {2'd3, 8'd2, 9'd100, 1'b1});
      lcd_en = 1'b0;
      dot_en = 1'b0;
      tick();
      check("off_state", {mode, ly, dot, lyc_match}, 0);
      dot_en = 1'b1;
      n_stat = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (oam_start | draw_start | draw_timeout | vblank_irq | stat_irq | (dot != 0)) n_stat++;
      end
      check("off_quiet", n_stat, 0);
      lcd_en = 1'b1;
      dot_en = 1'b0;
      tick();
      check("on_wait_dot_en", {oam_start, mode}, 0);
      dot_en = 1'b1;
      tick();
      check("reon_oam_start", {oam_start, mode, dot}, {1'b1, 2'd2, 9'd0});

      // ---------------- dot_en one cycle in three ----------------
      n_ds = 0; ds_dot = -1; n_en = 0;
      for (int i = 0; i < 300; i++) begin
         dot_en = (i % 3 == 0);
         if (dot_en) n_en++;
         tick();
         if (draw_start) begin
            n_ds++;
            ds_dot = dot;
         end
      end
      dot_en = 1'b0;
      check("slow_draw_cnt", n_ds, 1);
      check("slow_draw_dot", ds_dot, 80);
      check("slow_pos", {mode, dot}, {2'd3, 9'(n_en)});

      // ---------------- asynchronous reset mid-line ----------------
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst", {mode, ly, dot, lyc_match, oam_start, draw_start, draw_timeout, vblank_irq, stat_irq}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ppu_timing_ctrl.md
# ppu_timing_ctrl

Scan-line and frame sequencer for the PPU. Owns the dot counter, LY, and the current `ppu_mode_t`. Issues start strobes to the OAM-scan and pixel-fetch datapaths and takes back their completion. Generates the VBlank interrupt and the edge-detected STAT interrupt for the interrupt controller. Sits between the LCD register file (LCDC/STAT/LYC) and the pixel pipeline.

## Interface
Parameters:
- DOTS_PER_LINE, 456, dots per scan line
- LINES_PER_FRAME, 154, lines per frame including VBlank
- VISIBLE_LINES, 144, first VBlank line index
- OAM_DOTS, 80, length of mode 2
- MODE3_MAX_DOTS, 289, watchdog length of mode 3

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- dot_en  in  1  advance one dot this cycle
- lcd_en  in  1  LCDC[7]
- lyc  in  8  LYC register
- stat_ie  in  4  STAT[6:3]: bit0 mode0, bit1 mode1, bit2 mode2, bit3 LYC source enable
- draw_done  in  1  pixel pipeline has pushed 160 pixels
- mode  out  2  current mode, `ppu_mode_t`
- ly  out  8  current line
- dot  out  9  dot index within the line
- lyc_match  out  1  registered LY==LYC
- oam_start  out  1  one-cycle strobe: mode 2 begins
- draw_start  out  1  one-cycle strobe: mode 3 begins
- draw_timeout  out  1  one-cycle strobe: mode 3 forced to end
- vblank_irq  out  1  one-cycle request
- stat_irq  out  1  one-cycle request

## Operation
- Reset values (async, immediate): dot=0, ly=0, mode=PPU_MODE_0, lyc_match=0, all strobes and IRQs=0, stat_line_q=0, state OFF.
- States:
  - OFF: lcd_en=0.
  - OAM: mode 2.
  - DRAW: mode 3.
  - HBLANK: mode 0.
  - VBLANK: mode 1.
- OFF: dot and ly held at 0, mode=PPU_MODE_0, lyc_match=0, no IRQs.
  - Deasserting lcd_en in any state enters OFF on the next clk, regardless of dot_en.
- OFF -> OAM on the first dot_en cycle with lcd_en=1. That cycle: dot=0, ly=0, oam_start pulses.
- Dot advance happens only on dot_en cycles:
  - dot increments.
  - At dot=DOTS_PER_LINE-1 it wraps to 0 and ly increments.
  - ly wraps LINES_PER_FRAME-1 -> 0.
- Visible lines (ly<VISIBLE_LINES):
  - dot 0..OAM_DOTS-1: OAM.
  - Entering dot=OAM_DOTS: DRAW, draw_start pulses.
  - DRAW -> HBLANK on the dot_en cycle where draw_done=1. dot advances normally on that cycle.
  - If no draw_done arrives, entering dot=OAM_DOTS+MODE3_MAX_DOTS forces HBLANK and pulses draw_timeout.
  - draw_done outside DRAW is ignored.
  - HBLANK holds until the line wraps.
  - Wrap to a visible line -> OAM with oam_start.
- Entering ly=VISIBLE_LINES, dot=0 -> VBLANK, vblank_irq pulses once. Remains in VBLANK through ly=LINES_PER_FRAME-1.
- Wrap to ly=0 -> OAM with oam_start.
- lyc_match: registered each clk as (ly==lyc) while not OFF. It reflects a lyc write one cycle later, independent of dot_en.
- STAT line: stat_line = (stat_ie[0]&HBLANK) | (stat_ie[1]&VBLANK) | (stat_ie[2]&OAM) | (stat_ie[3]&lyc_match).
  - Computed from registered state every clk.
  - stat_line_q registers it.
  - stat_irq = stat_line & ~stat_line_q (rising edge only; a continuously high line blocks further requests).
  - In OFF, stat_line=0 and stat_line_q clears.

## Timing
- All outputs are registered. Strobes and IRQs are high for exactly one clk.
- mode, dot and ly change in the same clk edge that consumes dot_en.
- draw_start, oam_start and vblank_irq assert in the same cycle the new mode/line becomes visible on the outputs.
- stat_irq asserts one clk after the mode/lyc_match change that raised stat_line.
- Mode 3 minimum length: 1 dot. A draw_done on the first DRAW dot_en ends it; mode 0 is visible from that edge.
- draw_done and a line wrap in the same cycle: wrap wins and a new OAM starts. draw_done is dropped.
- draw_timeout and draw_done on the same dot: treat as draw_done, no timeout strobe.
- dot_en low: all state frozen except lyc_match and the STAT edge logic.
- Line period is exactly DOTS_PER_LINE dot_en cycles. Frame period is 70224 dot_en cycles at defaults.

## Test plan
- Reset, lcd_en=1, dot_en=1 continuous, draw_done at dot 252:
  - oam_start at dot 0, draw_start at dot 80, mode 0 at dot 253, line wrap after 456 cycles.
- Run to ly=144:
  - vblank_irq pulses once, mode=1 for 10 lines, ly wraps 153->0 with oam_start.
  - Frame = 70224 dot_en cycles.
- Never assert draw_done:
  - draw_timeout at dot 369, mode 0 there, next line normal.
- lyc=5, stat_ie=4'b1000:
  - lyc_match rises with ly=5; stat_irq one cycle later, once only.
  - With stat_ie=4'b1001 and ly=5 in HBLANK, no second stat_irq at the mode 0 entry (blocking).
- Drop lcd_en mid-DRAW at ly=40:
  - Next clk dot=0, ly=0, mode=0, no IRQs.
  - Reassert: oam_start on the first dot_en.
- Toggle dot_en 1-of-3 cycles, assert rst_n low mid-line:
  - Timing scales by dot_en count.
  - Reset clears all outputs immediately, without a clock edge.
